// File: rtl/stash_seq_ctrl_if.sv
// Request/strobe bundle between the stopwatch front end, the sequencer and the Stash.
// The master drives the requests and the slave (the sequencer) drives the strobes and status.
interface stash_seq_ctrl_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 5
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] time_in;
   logic              lap_req;
   logic              step_req;
   logic              scan_req;
   logic [DATA_W-1:0] stash_sample_in;
   logic              stash_in_valid;
   logic              stash_next_sample;
   logic [CW-1:0]     stored_count;
   logic [IW-1:0]     show_index;
   logic              busy;

   modport master (
      output time_in, lap_req, step_req, scan_req,
      input  stash_sample_in, stash_in_valid, stash_next_sample,
             stored_count, show_index, busy
   );

   modport slave (
      input  time_in, lap_req, step_req, scan_req,
      output stash_sample_in, stash_in_valid, stash_next_sample,
             stored_count, show_index, busy
   );
endinterface

// File: rtl/stash_seq_ctrl.sv
// Sequencer in front of the Stash sample buffer: turns single-cycle lap/step/scan
// requests into Stash write/advance strobes and tracks stored count and shown index.
module stash_seq_ctrl #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned DEPTH      = 5,
   parameter int unsigned SCAN_TICKS = 4
) (
   input logic                clk,
   input logic                reset,
   stash_seq_ctrl_if.slave    bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
   localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_STEP, ST_SCAN} state_t;

   state_t            state_q, state_n;
   logic [DATA_W-1:0] sample_q, sample_n;
   logic              valid_q, valid_n;
   logic              next_q, next_n;
   logic [CW-1:0]     count_q, count_n;
   logic [IW-1:0]     idx_q, idx_n;
   logic              busy_q, busy_n;
   logic [TW-1:0]     tick_q, tick_n;
   logic [CW-1:0]     pulses_q, pulses_n;

   logic [IW-1:0]     idx_inc;
   logic [TW-1:0]     tick_adv;
   logic              do_write;

   // Register every state bit and output; reset drops strobes and counts at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         sample_q <= '0;
         valid_q  <= 1'b0;
         next_q   <= 1'b0;
         count_q  <= '0;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         tick_q   <= '0;
         pulses_q <= '0;
      end else begin
         state_q  <= state_n;
         sample_q <= sample_n;
         valid_q  <= valid_n;
         next_q   <= next_n;
         count_q  <= count_n;
         idx_q    <= idx_n;
         busy_q   <= busy_n;
         tick_q   <= tick_n;
         pulses_q <= pulses_n;
      end
   end

   // Next-state and next-output decode; strobes default low so they last one cycle.
   always_comb begin
      state_n  = state_q;
      sample_n = sample_q;
      valid_n  = 1'b0;
      next_n   = 1'b0;
      count_n  = count_q;
      idx_n    = idx_q;
      tick_n   = tick_q;
      pulses_n = pulses_q;
      do_write = 1'b0;

      idx_inc  = (CW'(idx_q) + CW'(1) == count_q) ? '0 : idx_q + IW'(1);
      tick_adv = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);

      case (state_q)
         ST_IDLE: begin
            if (bus.lap_req) begin
               do_write = 1'b1;
            end else if (bus.scan_req && count_q != '0) begin
               state_n  = ST_SCAN;
               tick_n   = '0;
               pulses_n = '0;
               // With a one-cycle period the first advance lands in the first SCAN cycle.
               if (TICK_LAST == '0) begin
                  next_n   = 1'b1;
                  idx_n    = idx_inc;
                  pulses_n = CW'(1);
               end
            end else if (bus.step_req && count_q != '0) begin
               state_n = ST_STEP;
               next_n  = 1'b1;
               idx_n   = idx_inc;
            end
         end
         ST_WRITE, ST_STEP: begin
            state_n = ST_IDLE;
         end
         ST_SCAN: begin
            if (bus.lap_req) begin
               do_write = 1'b1;
            end else if (next_q && pulses_q == count_q) begin
               state_n = ST_IDLE;
            end else begin
               // The pulse is raised one edge early so it is visible in the cycle the period completes.
               tick_n = tick_adv;
               if (tick_adv == TICK_LAST) begin
                  next_n   = 1'b1;
                  idx_n    = idx_inc;
                  pulses_n = pulses_q + CW'(1);
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      if (do_write) begin
         state_n  = ST_WRITE;
         sample_n = bus.time_in;
         valid_n  = 1'b1;
         next_n   = 1'b0;
         count_n  = (count_q == COUNT_MAX) ? count_q : count_q + CW'(1);
         idx_n    = '0;
      end

      busy_n = (state_n != ST_IDLE);
   end

   assign bus.stash_sample_in   = sample_q;
   assign bus.stash_in_valid    = valid_q;
   assign bus.stash_next_sample = next_q;
   assign bus.stored_count      = count_q;
   assign bus.show_index        = idx_q;
   assign bus.busy              = busy_q;
endmodule

// File: tb/tb_stash_seq_ctrl.sv
// Directed bench for stash_seq_ctrl: laps, steps, timed scan, scan abort, reset mid-scan.
module tb_stash_seq_ctrl;
   logic clk;
   logic reset;
   int   tests;
   int   fails;

   stash_seq_ctrl_if #(.DATA_W(8), .DEPTH(5)) bus ();

   stash_seq_ctrl #(.DATA_W(8), .DEPTH(5), .SCAN_TICKS(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_reqs();
      bus.lap_req  = 1'b0;
      bus.step_req = 1'b0;
      bus.scan_req = 1'b0;
   endtask

   task automatic lap(input logic [7:0] t);
      bus.time_in = t;
      bus.lap_req = 1'b1;
      cyc();
      bus.lap_req = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
   endtask

   initial begin
      int exp_cnt;
      int exp_idx;
      int saw_next;
      tests = 0;
      fails = 0;
      idle_reqs();
      bus.time_in = '0;

      // 1: reset then quiet
      do_reset();
      repeat (10) cyc();
      check("rst_valid", 32'(bus.stash_in_valid), 0);
      check("rst_next",  32'(bus.stash_next_sample), 0);
      check("rst_count", 32'(bus.stored_count), 0);
      check("rst_idx",   32'(bus.show_index), 0);
      check("rst_busy",  32'(bus.busy), 0);
      check("rst_sample", 32'(bus.stash_sample_in), 0);

      // 2: seven laps, count saturates at 5
      for (int t = 0; t < 7; t++) begin
         exp_cnt = (t + 1 > 5) ? 5 : t + 1;
         lap(8'(t));
         check("lap_valid",  32'(bus.stash_in_valid), 1);
         check("lap_sample", 32'(bus.stash_sample_in), 32'(t));
         check("lap_count",  32'(bus.stored_count), 32'(exp_cnt));
         check("lap_idx",    32'(bus.show_index), 0);
         check("lap_next",   32'(bus.stash_next_sample), 0);
         check("lap_busy",   32'(bus.busy), 1);
         cyc();
         check("lap_valid_end", 32'(bus.stash_in_valid), 0);
         check("lap_busy_end",  32'(bus.busy), 0);
         check("lap_hold",      32'(bus.stash_sample_in), 32'(t));
         cyc();
         cyc();
      end

      // 3: six steps over five samples
      for (int s = 0; s < 6; s++) begin
         exp_idx = (s + 1) % 5;
         bus.step_req = 1'b1;
         cyc();
         bus.step_req = 1'b0;
         check("step_next", 32'(bus.stash_next_sample), 1);
         check("step_idx",  32'(bus.show_index), 32'(exp_idx));
         check("step_valid", 32'(bus.stash_in_valid), 0);
         cyc();
         check("step_next_end", 32'(bus.stash_next_sample), 0);
         cyc();
      end

      // 4: scan over three samples, entry index 1
      do_reset();
      lap(8'h10); cyc(); cyc();
      lap(8'h11); cyc(); cyc();
      lap(8'h12); cyc(); cyc();
      bus.step_req = 1'b1;
      cyc();
      bus.step_req = 1'b0;
      cyc();
      check("scan_pre_idx", 32'(bus.show_index), 1);
      check("scan_pre_cnt", 32'(bus.stored_count), 3);
      bus.scan_req = 1'b1;
      cyc();
      bus.scan_req = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         check("scan_busy", 32'(bus.busy), 1);
         check("scan_next", 32'(bus.stash_next_sample), (c % 4 == 0) ? 1 : 0);
         check("scan_idx",  32'(bus.show_index), 32'((1 + c / 4) % 3));
         cyc();
      end
      check("scan_done_busy", 32'(bus.busy), 0);
      check("scan_done_next", 32'(bus.stash_next_sample), 0);
      check("scan_done_idx",  32'(bus.show_index), 1);

      // 5: abort scan with a lap
      cyc();
      bus.scan_req = 1'b1;
      cyc();
      bus.scan_req = 1'b0;
      repeat (4) cyc();
      check("abort_mid_idx", 32'(bus.show_index), 2);
      lap(8'hA5);
      check("abort_valid",  32'(bus.stash_in_valid), 1);
      check("abort_next",   32'(bus.stash_next_sample), 0);
      check("abort_sample", 32'(bus.stash_sample_in), 32'h0A5);
      check("abort_idx",    32'(bus.show_index), 0);
      check("abort_count",  32'(bus.stored_count), 4);
      saw_next = 0;
      for (int c = 0; c < 10; c++) begin
         cyc();
         if (bus.stash_next_sample) saw_next++;
      end
      check("abort_no_next", 32'(saw_next), 0);
      check("abort_busy",    32'(bus.busy), 0);

      // 5b: step and scan with nothing stored
      do_reset();
      bus.step_req = 1'b1;
      cyc();
      bus.step_req = 1'b0;
      check("empty_step_next", 32'(bus.stash_next_sample), 0);
      check("empty_step_busy", 32'(bus.busy), 0);
      bus.scan_req = 1'b1;
      cyc();
      bus.scan_req = 1'b0;
      check("empty_scan_busy", 32'(bus.busy), 0);

      // 6: lap and scan together -> write only
      bus.time_in  = 8'h3C;
      bus.lap_req  = 1'b1;
      bus.scan_req = 1'b1;
      cyc();
      idle_reqs();
      check("both_valid",  32'(bus.stash_in_valid), 1);
      check("both_next",   32'(bus.stash_next_sample), 0);
      check("both_sample", 32'(bus.stash_sample_in), 32'h03C);
      cyc();
      check("both_busy_after", 32'(bus.busy), 0);
      cyc();
      check("both_no_scan", 32'(bus.busy), 0);

      // 6b: reset asserted while the scan pulse is high
      bus.scan_req = 1'b1;
      cyc();
      bus.scan_req = 1'b0;
      repeat (3) cyc();
      check("rscan_next_hi", 32'(bus.stash_next_sample), 1);
      reset = 1'b0;
      #1;
      check("rscan_next", 32'(bus.stash_next_sample), 0);
      check("rscan_count", 32'(bus.stored_count), 0);
      check("rscan_busy",  32'(bus.busy), 0);
      cyc();
      reset = 1'b1;
      repeat (6) cyc();
      check("rscan_idle_busy", 32'(bus.busy), 0);
      check("rscan_idle_next", 32'(bus.stash_next_sample), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
